// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Polyphonic voice allocator. Twelve raw key levels are synchronised and
//   edge-detected. Each edge sets a pending bit. A small FSM services one
//   pending event every two cycles, and releases always go before presses.
//   A press takes the lowest-index idle voice. If no voice is idle, it
//   steals the oldest voice.
//
// Ports
//   CLOCK_50     in   system clock (rising edge)
//   reset        in   synchronous, active-high reset
//   keys[11:0]   in   raw key levels; keys[i] -> tone code 12-i
//   voice_en     out  per-voice sounding flag
//   voice_tone   out  per-voice tone code in bits [4v+3:4v] (0 when idle)
//   voice_start  out  one-cycle pulse when voice v is (re)assigned
//   steal        out  one-cycle pulse alongside voice_start when a busy voice is evicted
//   busy         out  high while the FSM is in REL or PRESS
//
// There is no handshake: keys are free-running levels and the outputs are
// plain registered levels and pulses. Downstream has no way to stall.
module voice_scheduler #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [11:0]             keys,
  output logic [NUM_VOICES-1:0]   voice_en,
  output logic [4*NUM_VOICES-1:0] voice_tone,
  output logic [NUM_VOICES-1:0]   voice_start,
  output logic                    steal,
  output logic                    busy
);

  localparam int            AW         = $clog2(NUM_VOICES);
  localparam logic [AW-1:0] AGE_ONE    = AW'(1);
  localparam logic [AW-1:0] AGE_OLDEST = AW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REL, ST_PRESS} state_e;

  // Registers and their next-state values
  logic [11:0]           s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [11:0]           pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
  state_e                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [3:0]            tone_q [NUM_VOICES];
  logic [3:0]            tone_d [NUM_VOICES];
  logic [AW-1:0]         age_q  [NUM_VOICES];
  logic [AW-1:0]         age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] start_q, start_d;
  logic                  steal_q, steal_d, busy_q, busy_d;

  // Combinational helpers
  logic [11:0]   rise, fall, press_clr, rel_clr;
  logic [3:0]    rel_sel, press_sel, tone_k;
  logic          match_hit, idle_hit;
  logic [AW-1:0] match_v, idle_v, old_v, alloc_v;

  assign rise   = s2_q & ~prev_q;
  assign fall   = ~s2_q & prev_q;
  assign tone_k = 4'd12 - k_q;

  // Highest set pending bit. The last assignment in the loop wins, so this
  // picks the lowest tone first.
  always_comb begin
    rel_sel   = '0;
    press_sel = '0;
    for (int i = 0; i < 12; i++) begin
      if (pend_rel_q[i])   rel_sel   = 4'(i);
      if (pend_press_q[i]) press_sel = 4'(i);
    end
  end

  // Voice search. Tones are unique across voices, so at most one voice
  // matches tone_k. The idle-voice loop runs downwards so that the lowest
  // index wins.
  always_comb begin
    match_hit = 1'b0;
    match_v   = '0;
    idle_hit  = 1'b0;
    idle_v    = '0;
    old_v     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (en_q[v] && tone_q[v] == tone_k) begin
        match_hit = 1'b1;
        match_v   = AW'(v);
      end
      if (en_q[v] && age_q[v] == AGE_OLDEST) old_v = AW'(v);
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!en_q[v]) begin
        idle_hit = 1'b1;
        idle_v   = AW'(v);
      end
    end
    alloc_v = idle_hit ? idle_v : old_v;
  end

  always_comb begin
    s1_d      = keys;
    s2_d      = s1_q;
    prev_d    = s2_q;
    state_d   = state_q;
    k_d       = k_q;
    en_d      = en_q;
    tone_d    = tone_q;
    age_d     = age_q;
    start_d   = '0;
    steal_d   = 1'b0;
    press_clr = '0;
    rel_clr   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_rel_q != '0) begin
          state_d = ST_REL;
          k_d     = rel_sel;
        end else if (pend_press_q != '0) begin
          state_d = ST_PRESS;
          k_d     = press_sel;
        end
      end

      ST_REL: begin
        rel_clr[k_q] = 1'b1;
        // A release whose voice was already stolen, or never allocated,
        // finds no match and does nothing.
        if (match_hit) begin
          // Close the age gap left by the departing voice.
          for (int u = 0; u < NUM_VOICES; u++) begin
            if (en_q[u] && age_q[u] > age_q[match_v]) age_d[u] = age_q[u] - AGE_ONE;
          end
          en_d[match_v]   = 1'b0;
          tone_d[match_v] = '0;
          age_d[match_v]  = '0;
        end
        state_d = ST_IDLE;
      end

      ST_PRESS: begin
        press_clr[k_q] = 1'b1;
        // A key that has already gone low by service time is dropped.
        if (s2_q[k_q]) begin
          // Every active voice gets one step older. The stolen voice would
          // wrap here, but its age is overwritten just below.
          for (int u = 0; u < NUM_VOICES; u++) begin
            if (en_q[u]) age_d[u] = age_q[u] + AGE_ONE;
          end
          en_d[alloc_v]    = 1'b1;
          tone_d[alloc_v]  = tone_k;
          age_d[alloc_v]   = '0;
          start_d[alloc_v] = 1'b1;
          steal_d          = ~idle_hit;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // When a new edge and a service clear hit the same bit in one cycle,
    // the new edge must survive.
    pend_press_d = (pend_press_q & ~press_clr) | rise;
    pend_rel_d   = (pend_rel_q & ~rel_clr) | fall;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      prev_q       <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      state_q      <= ST_IDLE;
      k_q          <= '0;
      en_q         <= '0;
      tone_q       <= '{default: '0};
      age_q        <= '{default: '0};
      start_q      <= '0;
      steal_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      prev_q       <= prev_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      state_q      <= state_d;
      k_q          <= k_d;
      en_q         <= en_d;
      tone_q       <= tone_d;
      age_q        <= age_d;
      start_q      <= start_d;
      steal_q      <= steal_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    voice_tone = '0;
    for (int v = 0; v < NUM_VOICES; v++) voice_tone[4*v +: 4] = tone_q[v];
  end

  assign voice_en    = en_q;
  assign voice_start = start_q;
  assign steal       = steal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;
  localparam int NV = 4;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [11:0]       keys;
  logic [NV-1:0]     voice_en, voice_start;
  logic [4*NV-1:0]   voice_tone;
  logic              steal, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] cur_keys;

  // Clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  voice_scheduler #(.NUM_VOICES(NV)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .keys       (keys),
    .voice_en   (voice_en),
    .voice_tone (voice_tone),
    .voice_start(voice_start),
    .steal      (steal),
    .busy       (busy)
  );

  // Reference model: per-voice tone plus an age-ordered list of voices.
  // The front of the list is the newest voice and the back is the oldest.
  logic       m_en   [NV];
  logic [3:0] m_tone [NV];
  int         m_order[$];

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_en[v]   = 1'b0;
      m_tone[v] = '0;
    end
    m_order.delete();
  endfunction

  function automatic void model_release(input int tone);
    for (int v = 0; v < NV; v++) begin
      if (m_en[v] && m_tone[v] == 4'(tone)) begin
        m_en[v]   = 1'b0;
        m_tone[v] = '0;
        for (int j = 0; j < m_order.size(); j++) begin
          if (m_order[j] == v) begin
            m_order.delete(j);
            break;
          end
        end
      end
    end
  endfunction

  // Returns 1 when the press steals a voice.
  function automatic bit model_press(input int tone, output int v);
    bit st;
    if (m_order.size() < NV) begin
      v = 0;
      for (int i = NV - 1; i >= 0; i--) if (!m_en[i]) v = i;
      st = 1'b0;
    end else begin
      v  = m_order.pop_back();
      st = 1'b1;
    end
    m_order.push_front(v);
    m_en[v]   = 1'b1;
    m_tone[v] = 4'(tone);
    return st;
  endfunction

  function automatic logic [NV-1:0] exp_en();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_en[v];
    return r;
  endfunction

  function automatic logic [4*NV-1:0] exp_tone();
    logic [4*NV-1:0] r;
    for (int v = 0; v < NV; v++) r[4*v +: 4] = m_tone[v];
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys  = '0;
    step();
    step();
    reset = 1'b0;
    cur_keys = '0;
    model_reset();
  endtask

  // Steps until a voice_start pulse appears, or until max cycles have passed.
  task automatic wait_start(input int max, output int cyc, output logic [NV-1:0] st,
                            output logic stl, output bit to);
    cyc = 0;
    to  = 1'b1;
    st  = '0;
    stl = 1'b0;
    while (cyc < max) begin
      step();
      cyc++;
      if (voice_start != '0) begin
        st  = voice_start;
        stl = steal;
        to  = 1'b0;
        break;
      end
    end
  endtask

  // Applies a new key vector, lets it settle, and checks the result against the model.
  task automatic apply_keys(input logic [11:0] nk, input string name);
    int es, et, starts, steals, v;
    es = 0; et = 0; starts = 0; steals = 0;
    for (int i = 0; i < 12; i++) if (cur_keys[i] && !nk[i]) model_release(12 - i);
    for (int i = 11; i >= 0; i--) begin
      if (nk[i] && !cur_keys[i]) begin
        es++;
        if (model_press(12 - i, v)) et++;
      end
    end
    keys = nk;
    cur_keys = nk;
    repeat (60) begin
      step();
      starts += $countones(voice_start);
      if (steal) steals++;
    end
    n_tests++;
    if (voice_en !== exp_en()) begin
      n_fail++; $display("FAIL %s en: got %b expected %b", name, voice_en, exp_en());
    end
    n_tests++;
    if (voice_tone !== exp_tone()) begin
      n_fail++; $display("FAIL %s tone: got %h expected %h", name, voice_tone, exp_tone());
    end
    n_tests++;
    if (starts != es) begin
      n_fail++; $display("FAIL %s start_count: got %0d expected %0d", name, starts, es);
    end
    n_tests++;
    if (steals != et) begin
      n_fail++; $display("FAIL %s steal_count: got %0d expected %0d", name, steals, et);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_idle: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = 12'hFFF;
    repeat (3) step();
    n_tests++;
    if ({voice_en, voice_tone, voice_start, steal, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b tone=%h start=%b steal=%b busy=%b expected all 0",
               voice_en, voice_tone, voice_start, steal, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    int v;
    do_reset();
    keys = 12'h800;
    cur_keys = 12'h800;
    void'(model_press(1, v));
    repeat (4) step();
    n_tests++;
    if (voice_en !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_pre: got en=%b busy=%b expected en=0000 busy=1", voice_en, busy);
    end
    step();
    n_tests++;
    if (voice_en !== 4'b0001 || voice_tone[3:0] !== 4'd1 || voice_start !== 4'b0001 || steal !== 1'b0) begin
      n_fail++;
      $display("FAIL single_alloc: got en=%b tone0=%0d start=%b steal=%b expected 0001/1/0001/0",
               voice_en, voice_tone[3:0], voice_start, steal);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_drop: got %b expected 0", busy);
    end
    step();
    n_tests++;
    if (voice_start !== 4'b0000) begin
      n_fail++; $display("FAIL single_start_pulse: got %b expected 0000", voice_start);
    end
    repeat (14) step();
    keys = 12'h000;
    cur_keys = 12'h000;
    model_release(1);
    repeat (4) step();
    n_tests++;
    if (voice_en !== 4'b0001) begin
      n_fail++; $display("FAIL single_rel_pre: got %b expected 0001", voice_en);
    end
    step();
    n_tests++;
    if (voice_en !== exp_en() || voice_tone !== exp_tone()) begin
      n_fail++; $display("FAIL single_rel: got en=%b tone=%h expected %b %h", voice_en, voice_tone, exp_en(), exp_tone());
    end
  endtask

  task automatic test_steal();
    int cyc, v;
    logic [NV-1:0] st;
    logic stl, est;
    bit to;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      cur_keys = cur_keys | (12'h800 >> j);
      keys = cur_keys;
      est = model_press(j + 1, v);
      wait_start(20, cyc, st, stl, to);
      n_tests++;
      if (to || st !== NV'(1 << v) || stl !== est || voice_tone[4*v +: 4] !== 4'(j + 1)) begin
        n_fail++;
        $display("FAIL steal_press%0d: got start=%b steal=%b tone=%0d timeout=%0d expected start=%b steal=%b tone=%0d",
                 j, st, stl, voice_tone[4*v +: 4], to, NV'(1 << v), est, j + 1);
      end
      repeat (5) step();
    end
    n_tests++;
    if (voice_tone !== 16'h4325 || voice_en !== 4'b1111) begin
      n_fail++; $display("FAIL steal_final: got en=%b tone=%h expected 1111 4325", voice_en, voice_tone);
    end
    apply_keys(cur_keys & ~12'h800, "steal_rel_noop");
    apply_keys(cur_keys | 12'h040, "steal_oldest");
    n_tests++;
    if (voice_tone !== 16'h4365) begin
      n_fail++; $display("FAIL steal_age_order: got %h expected 4365", voice_tone);
    end
    apply_keys(12'h000, "steal_clear");
  endtask

  task automatic test_simultaneous();
    int cyc, v;
    logic [NV-1:0] st;
    logic stl, est;
    bit to;
    do_reset();
    keys = 12'hFFF;
    cur_keys = 12'hFFF;
    for (int j = 0; j < 12; j++) begin
      est = model_press(j + 1, v);
      wait_start(20, cyc, st, stl, to);
      n_tests++;
      if (to || cyc != ((j == 0) ? 5 : 2) || st !== NV'(1 << v) || stl !== est ||
          voice_tone[4*v +: 4] !== 4'(j + 1)) begin
        n_fail++;
        $display("FAIL simul_%0d: got cyc=%0d start=%b steal=%b tone=%0d expected cyc=%0d start=%b steal=%b tone=%0d",
                 j, cyc, st, stl, voice_tone[4*v +: 4], (j == 0) ? 5 : 2, NV'(1 << v), est, j + 1);
      end
    end
    repeat (5) step();
    n_tests++;
    if (voice_tone !== 16'hCBA9 || voice_en !== 4'b1111) begin
      n_fail++; $display("FAIL simul_final: got en=%b tone=%h expected 1111 cba9", voice_en, voice_tone);
    end
    apply_keys(12'h000, "simul_clear");
  endtask

  task automatic test_release_priority();
    int v;
    do_reset();
    apply_keys(12'h800, "prio_a");
    apply_keys(12'hC00, "prio_b");
    apply_keys(12'hE00, "prio_c");
    keys = 12'hA10;
    cur_keys = 12'hA10;
    model_release(2);
    void'(model_press(8, v));
    repeat (5) step();
    n_tests++;
    if (voice_en !== 4'b0101 || voice_start !== 4'b0000) begin
      n_fail++; $display("FAIL prio_release_first: got en=%b start=%b expected 0101 0000", voice_en, voice_start);
    end
    repeat (2) step();
    n_tests++;
    if (voice_start !== 4'b0010 || voice_en !== 4'b0111 || voice_tone[7:4] !== 4'd8 || steal !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_reuse_slot: got start=%b en=%b tone1=%0d steal=%b expected 0010 0111 8 0",
               voice_start, voice_en, voice_tone[7:4], steal);
    end
    repeat (6) step();
    apply_keys(12'hA18, "prio_fill");
    apply_keys(12'hA1C, "prio_steal");
    n_tests++;
    if (voice_tone !== 16'h938A) begin
      n_fail++; $display("FAIL prio_age_compact: got %h expected 938a", voice_tone);
    end
    apply_keys(12'h000, "prio_clear");
  endtask

  task automatic test_glitch();
    int starts, steals, v;
    bit saw7;
    do_reset();
    keys = 12'hF20;
    step();
    step();
    keys = 12'hF00;
    cur_keys = 12'hF00;
    for (int t = 1; t <= 4; t++) void'(model_press(t, v));
    starts = 0; steals = 0; saw7 = 1'b0;
    repeat (40) begin
      step();
      starts += $countones(voice_start);
      if (steal) steals++;
      for (int u = 0; u < NV; u++) if (voice_start[u] && voice_tone[4*u +: 4] == 4'd7) saw7 = 1'b1;
    end
    n_tests++;
    if (starts != 4 || steals != 0 || saw7) begin
      n_fail++; $display("FAIL glitch_drop: got starts=%0d steals=%0d tone7=%0d expected 4 0 0", starts, steals, saw7);
    end
    n_tests++;
    if (voice_tone !== exp_tone() || busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_state: got tone=%h busy=%b expected %h 0", voice_tone, busy, exp_tone());
    end
    starts = 0;
    repeat (10) begin
      step();
      starts += $countones(voice_start) + int'(busy);
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++; $display("FAIL glitch_pending_clear: got activity=%0d expected 0", starts);
    end
    apply_keys(12'h000, "glitch_clear");
  endtask

  task automatic test_reset_mid();
    int cyc, v;
    logic [NV-1:0] st;
    logic stl;
    bit to;
    do_reset();
    keys = 12'h001;
    repeat (4) step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_press: got busy=%b expected 1", busy);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if ({voice_en, voice_tone, voice_start, steal, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got en=%b tone=%h start=%b steal=%b busy=%b expected all 0",
               voice_en, voice_tone, voice_start, steal, busy);
    end
    reset = 1'b0;
    model_reset();
    cur_keys = 12'h001;
    void'(model_press(12, v));
    wait_start(20, cyc, st, stl, to);
    n_tests++;
    if (to || cyc != 5 || st !== NV'(1 << v) || voice_tone !== exp_tone()) begin
      n_fail++;
      $display("FAIL rstmid_realloc: got cyc=%0d start=%b tone=%h timeout=%0d expected 5 %b %h",
               cyc, st, voice_tone, to, NV'(1 << v), exp_tone());
    end
    repeat (6) step();
    apply_keys(12'h000, "rstmid_clear");
  endtask

  task automatic test_random();
    logic [11:0] mask;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mask = 12'($urandom_range(0, 4095) & $urandom_range(0, 4095));
      apply_keys(cur_keys ^ mask, $sformatf("rand%0d", it));
    end
    apply_keys(12'h000, "rand_clear");
  endtask

  initial begin
    reset = 1'b1;
    keys = '0;
    cur_keys = '0;
    model_reset();
    test_reset();
    test_single();
    test_steal();
    test_simultaneous();
    test_release_priority();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
